// File: rtl/rr_dispatch.sv
// -----------------------------------------------------------------------------
// rr_dispatch
//
// Round-robin fan-out stage. A single valid/stall input stream is spread over
// NUM_OUT valid/stall output streams. Each output owns a private 2-entry queue,
// so a stalled downstream unit only blocks its own queue. An accepted item is
// visible on valid_ds no earlier than the cycle after it was accepted.
//
// Optional feature macro: RR_DISPATCH_STATS_EN
//   defined   : dispatch_cnt[i] counts accepts routed to output i, saturating
//               at all-ones, cleared only by reset.
//   undefined : dispatch_cnt is tied to zero and no counter flops exist.
//
// Ports
//   clk          in   single clock, all state updates on posedge
//   rst          in   synchronous active-low reset
//   valid_us     in   upstream payload valid
//   data_us      in   upstream payload [WIDTH-1:0]
//   stall_us     out  1 = payload not taken this cycle, upstream must hold it
//   valid_ds     out  per-output queue head valid [NUM_OUT-1:0]
//   data_ds      out  per-output queue head [NUM_OUT-1:0][WIDTH-1:0], 0 when empty
//   stall_ds     in   per-output downstream stall [NUM_OUT-1:0]
//   dispatch_cnt out  per-output accept count [NUM_OUT-1:0][CNT_W-1:0]
// -----------------------------------------------------------------------------
module rr_dispatch #(
    parameter int NUM_OUT = 4,
    parameter int WIDTH   = 10,
    parameter int CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_us,
    input  logic [WIDTH-1:0]              data_us,
    output logic                          stall_us,
    output logic [NUM_OUT-1:0]            valid_ds,
    output logic [NUM_OUT-1:0][WIDTH-1:0] data_ds,
    input  logic [NUM_OUT-1:0]            stall_ds,
    output logic [NUM_OUT-1:0][CNT_W-1:0] dispatch_cnt
);

    localparam int               PTR_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [PTR_W:0]   NUM_OUT_W = (PTR_W + 1)'(NUM_OUT);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_OUT - 1);

    // Per-output queue state
    logic [NUM_OUT-1:0][1:0][WIDTH-1:0] mem_q, mem_d;
    logic [NUM_OUT-1:0][1:0]            cnt_q, cnt_d;
    logic [NUM_OUT-1:0]                 rd_q, rd_d;
    logic [NUM_OUT-1:0]                 wr_q, wr_d;

    // Round-robin start point for the next search
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_OUT-1:0] free;
    logic [NUM_OUT-1:0] pop;
    logic [NUM_OUT-1:0] push;
    logic               any_free;
    logic               accept;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W:0]     idx;

    // Queue heads and per-output status, all from registered state only.
    // NOTE: every signal written in an always_comb gets a value before any
    // conditional logic, so no path can leave it unassigned and infer a latch.
    always_comb begin
        valid_ds = '0;
        data_ds  = '0;
        free     = '0;
        pop      = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            valid_ds[i] = (cnt_q[i] != 2'd0);
            data_ds[i]  = (cnt_q[i] != 2'd0) ? mem_q[i][rd_q[i]] : '0;
            // A same-cycle pop does not make room for a same-cycle push.
            free[i]     = (cnt_q[i] < 2'd2);
            pop[i]      = (cnt_q[i] != 2'd0) && !stall_ds[i];
        end
    end

    // First free output scanning upward from rr_ptr, wrapping at NUM_OUT.
    always_comb begin
        any_free = 1'b0;
        sel      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            idx = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
            if (idx >= NUM_OUT_W) begin
                idx = idx - NUM_OUT_W;
            end
            if (!any_free && free[idx[PTR_W-1:0]]) begin
                any_free = 1'b1;
                sel      = idx[PTR_W-1:0];
            end
        end
    end

    // While in reset the input is always stalled, so nothing is accepted in
    // the reset cycle.
    assign stall_us = valid_us & (~any_free | ~rst);
    assign accept   = valid_us & ~stall_us;

    // Next-state for queues and the round-robin pointer.
    always_comb begin
        mem_d    = mem_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        rr_ptr_d = rr_ptr_q;
        push     = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            push[i] = accept && (sel == PTR_W'(i));
            if (push[i]) begin
                mem_d[i][wr_q[i]] = data_us;
                wr_d[i]           = ~wr_q[i];
            end
            if (pop[i]) begin
                rd_d[i] = ~rd_q[i];
            end
            case ({push[i], pop[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + 2'd1;
                2'b01:   cnt_d[i] = cnt_q[i] - 2'd1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
        if (accept) begin
            rr_ptr_d = (sel == LAST_IDX) ? '0 : sel + PTR_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: queue storage is cleared along with the control state so
            // the post-reset contents are fully defined, not just the counts.
            mem_q    <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef RR_DISPATCH_STATS_EN
    logic [NUM_OUT-1:0][CNT_W-1:0] dispatch_cnt_q, dispatch_cnt_d;

    // Saturating per-output accept counters.
    always_comb begin
        dispatch_cnt_d = dispatch_cnt_q;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (push[i] && (dispatch_cnt_q[i] != '1)) begin
                dispatch_cnt_d[i] = dispatch_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dispatch_cnt_q <= '0;
        end else begin
            dispatch_cnt_q <= dispatch_cnt_d;
        end
    end

    assign dispatch_cnt = dispatch_cnt_q;
`else
    assign dispatch_cnt = '0;
`endif

endmodule

// File: tb/tb_rr_dispatch.sv
// -----------------------------------------------------------------------------
// tb_rr_dispatch
//
// Directed bench for rr_dispatch (NUM_OUT=4, WIDTH=10, CNT_W=4). Stimulus
// pushes each accepted item onto the expected queue of the output it must land
// in; an independent monitor pops and compares whenever an output transfers.
// stall_us, valid_ds and dispatch_cnt are checked against hand-derived values.
// -----------------------------------------------------------------------------
module tb_rr_dispatch;

    localparam int NUM_OUT = 4;
    localparam int WIDTH   = 10;
    localparam int CNT_W   = 4;

`ifdef RR_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                          clk = 1'b0;
    logic                          rst = 1'b0;
    logic                          valid_us = 1'b0;
    logic [WIDTH-1:0]              data_us = '0;
    logic                          stall_us;
    logic [NUM_OUT-1:0]            valid_ds;
    logic [NUM_OUT-1:0][WIDTH-1:0] data_ds;
    logic [NUM_OUT-1:0]            stall_ds = '0;
    logic [NUM_OUT-1:0][CNT_W-1:0] dispatch_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    logic [WIDTH-1:0] exp_q [NUM_OUT][$];

    // Destinations for the 12 items of the single-stalled-output run.
    int t2_out [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 2, 3, 1};

    always #5 clk = ~clk;

    rr_dispatch #(
        .NUM_OUT(NUM_OUT),
        .WIDTH  (WIDTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_us    (valid_us),
        .data_us     (data_us),
        .stall_us    (stall_us),
        .valid_ds    (valid_ds),
        .data_ds     (data_ds),
        .stall_ds    (stall_ds),
        .dispatch_cnt(dispatch_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus. Entered just after a posedge, returns just after
    // the next one. Expected stall and valid_ds are checked at the negedge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d,
                         input logic [NUM_OUT-1:0] sds, input logic exp_stall,
                         input int exp_out, input logic chk_vds,
                         input logic [NUM_OUT-1:0] exp_vds);
        valid_us = v;
        data_us  = d;
        stall_ds = sds;
        @(negedge clk);
        check($sformatf("stall_us(d=%0d)", d), {31'd0, stall_us}, {31'd0, exp_stall});
        if (chk_vds) begin
            check($sformatf("valid_ds(d=%0d)", d), {28'd0, valid_ds}, {28'd0, exp_vds});
        end
        if (v && !exp_stall) begin
            exp_q[exp_out].push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [NUM_OUT-1:0] sds, input int n);
        for (int k = 0; k < n; k++) begin
            cycle(1'b0, '0, sds, 1'b0, 0, 1'b0, '0);
        end
    endtask

    task automatic flush_exp();
        for (int i = 0; i < NUM_OUT; i++) begin
            exp_q[i].delete();
        end
    endtask

    task automatic check_drained(input string tag);
        for (int i = 0; i < NUM_OUT; i++) begin
            check($sformatf("%s_out%0d_left", tag, i), exp_q[i].size(), 32'd0);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        valid_us = 1'b0;
        stall_ds = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        flush_exp();
    endtask

    // Scoreboard monitor: every transfer on an output must match the oldest
    // expected item for that output.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (valid_ds[i] && !stall_ds[i]) begin
                    if (exp_q[i].size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL out%0d_spurious: got 0x%0h, expected no item", i, data_ds[i]);
                    end else begin
                        check($sformatf("out%0d_data", i), {22'd0, data_ds[i]}, {22'd0, exp_q[i].pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        // Power-on reset
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_valid_ds", {28'd0, valid_ds}, 32'd0);
        check("rst_stall_us", {31'd0, stall_us}, 32'd0);
        check("rst_data_ds", {22'd0, data_ds[0] | data_ds[1] | data_ds[2] | data_ds[3]}, 32'd0);
        check("rst_dispatch_cnt", {16'd0, dispatch_cnt}, 32'd0);
        @(posedge clk);
        #1;

        // Four items, nothing stalled: one per output, each visible one cycle later
        cycle(1'b1, 10'd1, 4'b0000, 1'b0, 0, 1'b1, 4'b0000);
        cycle(1'b1, 10'd2, 4'b0000, 1'b0, 1, 1'b1, 4'b0001);
        cycle(1'b1, 10'd3, 4'b0000, 1'b0, 2, 1'b1, 4'b0010);
        cycle(1'b1, 10'd4, 4'b0000, 1'b0, 3, 1'b1, 4'b0100);
        cycle(1'b0, 10'd0, 4'b0000, 1'b0, 0, 1'b1, 4'b1000);
        cycle(1'b0, 10'd0, 4'b0000, 1'b0, 0, 1'b1, 4'b0000);
        check_drained("basic");

        // Output 0 stalled: it takes 1 and 5, then is skipped
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 10'(i + 1), 4'b0001, 1'b0, t2_out[i], 1'b0, '0);
        end
        cycle(1'b0, 10'd0, 4'b0001, 1'b0, 0, 1'b1, 4'b0011);
        idle(4'b0000, 3);
        check_drained("one_stalled");

        // All stalled from rr_ptr=2: 8 accepts, then full
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 10'(13 + i), 4'b1111, 1'b0, (2 + i) % NUM_OUT, 1'b0, '0);
        end
        cycle(1'b1, 10'd21, 4'b1111, 1'b1, 0, 1'b0, '0);
        cycle(1'b1, 10'd21, 4'b1111, 1'b1, 0, 1'b0, '0);
        cycle(1'b0, 10'd21, 4'b1111, 1'b0, 0, 1'b1, 4'b1111);
        cycle(1'b1, 10'd21, 4'b1111, 1'b1, 0, 1'b0, '0);
        // Release output 2: first pop frees it only for the following cycle
        cycle(1'b1, 10'd21, 4'b1011, 1'b1, 0, 1'b0, '0);
        cycle(1'b1, 10'd21, 4'b1011, 1'b0, 2, 1'b0, '0);
        cycle(1'b0, 10'd0,  4'b1011, 1'b0, 0, 1'b1, 4'b1111);
        idle(4'b0000, 3);
        check_drained("all_stalled");

        // Push and pop on output 1 in the same cycle (rr_ptr starts at 3)
        cycle(1'b1, 10'd30, 4'b1111, 1'b0, 3, 1'b0, '0);
        cycle(1'b1, 10'd31, 4'b1111, 1'b0, 0, 1'b0, '0);
        cycle(1'b1, 10'd32, 4'b1111, 1'b0, 1, 1'b0, '0);
        cycle(1'b1, 10'd33, 4'b1111, 1'b0, 2, 1'b0, '0);
        cycle(1'b1, 10'd34, 4'b1111, 1'b0, 3, 1'b0, '0);
        cycle(1'b1, 10'd35, 4'b1111, 1'b0, 0, 1'b0, '0);
        cycle(1'b1, 10'd36, 4'b1101, 1'b0, 1, 1'b1, 4'b1111);
        cycle(1'b0, 10'd0,  4'b1101, 1'b0, 0, 1'b1, 4'b1111);
        cycle(1'b0, 10'd0,  4'b1101, 1'b0, 0, 1'b1, 4'b1101);
        idle(4'b0000, 3);
        check_drained("push_pop");

        // Reset with 5 items queued (rr_ptr starts at 2)
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 10'(40 + i), 4'b1111, 1'b0, (2 + i) % NUM_OUT, 1'b0, '0);
        end
        rst      = 1'b0;
        valid_us = 1'b1;
        data_us  = 10'd45;
        stall_ds = 4'b0000;
        @(negedge clk);
        check("mid_rst_stall_us", {31'd0, stall_us}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        flush_exp();
        valid_us = 1'b0;
        @(negedge clk);
        check("mid_rst_valid_ds", {28'd0, valid_ds}, 32'd0);
        check("mid_rst_stall_us_idle", {31'd0, stall_us}, 32'd0);
        check("mid_rst_dispatch_cnt", {16'd0, dispatch_cnt}, 32'd0);
        @(posedge clk);
        #1;
        cycle(1'b1, 10'd50, 4'b0000, 1'b0, 0, 1'b1, 4'b0000);
        cycle(1'b0, 10'd0,  4'b0000, 1'b0, 0, 1'b1, 4'b0001);
        idle(4'b0000, 2);
        check_drained("mid_rst");

        // Saturating counter: 22 accepts to output 0, 2 to each other output
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 10'(60 + i), 4'b1111, 1'b0, i % NUM_OUT, 1'b0, '0);
        end
        cycle(1'b1, 10'd68, 4'b1110, 1'b1, 0, 1'b0, '0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 10'(68 + k), 4'b1110, 1'b0, 0, 1'b0, '0);
            if (k == 12) begin
                check("cnt0_at_15", {28'd0, dispatch_cnt[0]}, STATS ? 32'd15 : 32'd0);
            end
        end
        check("cnt0_saturated", {28'd0, dispatch_cnt[0]}, STATS ? 32'd15 : 32'd0);
        for (int i = 1; i < NUM_OUT; i++) begin
            check($sformatf("cnt%0d", i), {28'd0, dispatch_cnt[i]}, STATS ? 32'd2 : 32'd0);
        end
        idle(4'b0000, 3);
        check_drained("stats");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
